debug_uart_wb_bridge: RTL and testbench
=======================================

Name: debug_uart_wb_bridge

Overview:
- Device-side responder for the serial debug protocol that the testbench UART host drives (UART-to-Wishbone "uartbone" style).
- Receives 8N1 command frames on a serial input and performs Wishbone master reads and writes into the management SoC.
- Returns read data on a serial output.
- Sits between the debug UART pins and the SoC Wishbone interconnect as an additional bus master.

Parameters:
- CLK_DIV, 217, core_clk cycles per UART bit (min 4); the default gives 115200 baud at 25 MHz.
- TIMEOUT_CYCLES, 1000000, inter-byte idle limit used only with DEBUG_BRIDGE_TIMEOUT_EN.

Ports:
- core_clk  in  1  sole clock.
- core_rst  in  1  asynchronous active-high reset.
- ser_rx  in  1  serial command input, idle high.
- ser_tx  out  1  serial response output, idle high.
- wbm_adr_o  out  32  Wishbone byte address, always word aligned.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_sel_o  out  4  byte select, always 4'hF while cyc is asserted, else 0.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- busy  out  1  high from the command byte being accepted until the command completes.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values: all of the following are 0 or idle.
  - ser_tx=1; wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o=0; wbm_adr_o=0; wbm_dat_o=0; busy=0; frame_err=0.
  - FSM in IDLE; RX/TX bit counters cleared.
  - Reset asserted mid-command aborts immediately; no partial bus cycle survives.
- RX path:
  - ser_rx passes through a 2-flop synchronizer whose flops reset to 1.
  - A falling edge starts a frame; the line is re-sampled at CLK_DIV/2. If high there, it is a false start and is discarded.
  - Data bits are sampled every CLK_DIV cycles, LSB first, then the stop bit.
  - Stop bit = 0: byte dropped, frame_err pulses 1 cycle, and the parser state is unchanged.
  - A valid byte raises an internal rx_valid for 1 cycle.
- TX path:
  - Loads a byte only when idle.
  - Sends start bit 0, 8 data bits LSB first, stop bit 1, each held CLK_DIV cycles.
  - Back-to-back bytes are allowed with no extra idle bit.
- Protocol: every field is big-endian.
  - Byte 0: CMD (0x01 = write, 0x02 = read).
  - Byte 1: LEN (word count, 0 to 255).
  - Bytes 2-5: word address WA.
  - For a write, LEN x 4 data bytes follow.
- FSM states and transitions:
  - IDLE
    - 0x01 or 0x02 → LEN, busy=1.
    - Any other byte is ignored and the FSM stays in IDLE.
  - LEN → ADDR.
  - ADDR: collects 4 bytes. wbm_adr_o = {WA[29:0],2'b00}; WA[31:30] are ignored.
    - LEN=0 → IDLE, busy=0, no bus access.
    - Otherwise a write goes to WDATA and a read goes to RD_BUS.
  - WDATA: collects 4 bytes into wbm_dat_o → WR_BUS.
  - WR_BUS: cyc=stb=we=1 until ack or err, sampled on core_clk.
    - The cycle after the terminating ack/err, cyc/stb/we = 0.
    - Address += 4 (wraps mod 2^32); remaining count decrements.
    - Count reaches 0 → IDLE; otherwise → WDATA.
  - RD_BUS: cyc=stb=1, we=0 until ack or err.
    - On ack, latch wbm_dat_i; on err, latch 32'hFFFFFFFF.
    - → TX_DATA.
  - TX_DATA: sends the 4 latched bytes MSB first.
    - Then address += 4 and count decrements.
    - → RD_BUS, or → IDLE when count reaches 0.
- Bytes received in RD_BUS, WR_BUS or TX_DATA are discarded; the link is half-duplex.
- There is no bus timeout: a slave that never responds holds the bridge in *_BUS.
- ack and err asserted in the same cycle: treated as err.
- busy falls in the same cycle the FSM enters IDLE. For a read, that is after the last stop bit has finished.

Optional Feature:
- Macro: DEBUG_BRIDGE_TIMEOUT_EN.
- Defined: a counter clears on every rx_valid and counts while the FSM is in LEN, ADDR or WDATA. On reaching TIMEOUT_CYCLES, the FSM returns to IDLE and busy=0; no bus access is made for the partial word.
- Undefined: no counter exists, and a partial command waits indefinitely.

Test Plan:
- Write: host sends 01 01 00 00 04 00 DE AD BE EF (CLK_DIV=8). Expect exactly one WB write with adr=0x00001000, dat=0xDEADBEEF, sel=F, then busy=0.
- Read: slave returns 0x12345678 for adr 0x00001000; host sends 02 01 00 00 04 00. Expect ser_tx bytes 12 34 56 78, each with a correct start/stop bit.
- Burst read: LEN=3, WA=0x3FFFFFFF. Expect addresses 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap), and 12 response bytes.
- Error and idle cases:
  - Read with the slave asserting err: expect response FF FF FF FF.
  - LEN=0 command: expect no cyc.
  - Leading byte 0x55: ignored, and a following valid command still executes.
- Framing and reset:
  - Byte with stop bit 0: expect a frame_err pulse and the parser position unchanged.
  - core_rst pulsed while wbm_cyc_o=1: expect cyc=0 and ser_tx=1 asynchronously.
- With DEBUG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=200: send 01 02 and then stall. Expect busy=0 after 200 cycles and no bus cycle.

Source files
------------

// File: rtl/debug_uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: 8N1 command frames in, Wishbone master reads/writes, read data out.
// Optional inter-byte idle timeout enabled by defining DEBUG_BRIDGE_TIMEOUT_EN.
module debug_uart_wb_bridge #(
    parameter int unsigned CLK_DIV        = 217,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BitLast  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {
        StIdle, StLen, StAddr, StWdata, StWrBus, StRdBus, StTxData
    } state_e;

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e     rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          frame_err_q;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_st_q     <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= ser_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_st_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_st_q  <= RxStart;
                        rx_cnt_q <= HalfLast;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == '0) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        if (rx_s2_q) begin
                            rx_st_q <= RxIdle;
                        end else begin
                            rx_st_q  <= RxData;
                            rx_cnt_q <= BitLast;
                            rx_bit_q <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == '0) begin
                        rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
                        rx_cnt_q  <= BitLast;
                        if (rx_bit_q == 3'd7) begin
                            rx_st_q <= RxStop;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == '0) begin
                        rx_st_q <= RxIdle;
                        if (rx_s2_q) begin
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                default: rx_st_q <= RxIdle;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic          tx_act_q;
    logic [8:0]    tx_sh_q;
    logic [3:0]    tx_bits_q;
    logic [CW-1:0] tx_cnt_q;
    logic          ser_tx_q;
    logic          tx_ready;
    logic          tx_load;

    state_e      st_q;
    logic [2:0]  bidx_q;
    logic [31:0] rdata_q;

    // Ready again in the last cycle of the stop bit so bytes go out back-to-back.
    assign tx_ready = !tx_act_q || (tx_cnt_q == '0 && tx_bits_q == 4'd0);
    assign tx_load  = (st_q == StTxData) && (bidx_q != 3'd4) && tx_ready;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            tx_act_q  <= 1'b0;
            tx_sh_q   <= '1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
            ser_tx_q  <= 1'b1;
        end else if (tx_load) begin
            tx_act_q  <= 1'b1;
            ser_tx_q  <= 1'b0;
            tx_sh_q   <= {1'b1, rdata_q[31:24]};
            tx_bits_q <= 4'd9;
            tx_cnt_q  <= BitLast;
        end else if (tx_act_q) begin
            if (tx_cnt_q == '0) begin
                if (tx_bits_q == 4'd0) begin
                    tx_act_q <= 1'b0;
                    ser_tx_q <= 1'b1;
                end else begin
                    ser_tx_q  <= tx_sh_q[0];
                    tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                    tx_bits_q <= tx_bits_q - 4'd1;
                    tx_cnt_q  <= BitLast;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end
        end
    end

    // ---------------- idle timeout ----------------
    logic timeout_hit;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    logic        in_hdr;
    logic [31:0] to_cnt_q;

    assign in_hdr      = (st_q == StLen) || (st_q == StAddr) || (st_q == StWdata);
    assign timeout_hit = in_hdr && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            to_cnt_q <= '0;
        end else if (rx_valid_q || !in_hdr) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

    // ---------------- command FSM ----------------
    logic        is_wr_q;
    logic [7:0]  cnt_q;
    logic [1:0]  bcnt_q;
    logic [31:0] wa_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        cyc_q, stb_q, we_q, busy_q;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            st_q    <= StIdle;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            wa_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            bidx_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (timeout_hit) begin
            st_q   <= StIdle;
            busy_q <= 1'b0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (rx_valid_q && (rx_byte_q == 8'h01 || rx_byte_q == 8'h02)) begin
                        is_wr_q <= (rx_byte_q == 8'h01);
                        busy_q  <= 1'b1;
                        st_q    <= StLen;
                    end
                end
                StLen: begin
                    if (rx_valid_q) begin
                        cnt_q  <= rx_byte_q;
                        bcnt_q <= '0;
                        st_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (rx_valid_q) begin
                        wa_q   <= {wa_q[23:0], rx_byte_q};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            adr_q <= {wa_q[21:0], rx_byte_q, 2'b00};
                            if (cnt_q == 8'd0) begin
                                st_q   <= StIdle;
                                busy_q <= 1'b0;
                            end else if (is_wr_q) begin
                                st_q <= StWdata;
                            end else begin
                                st_q  <= StRdBus;
                                cyc_q <= 1'b1;
                                stb_q <= 1'b1;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (rx_valid_q) begin
                        dat_q  <= {dat_q[23:0], rx_byte_q};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            st_q  <= StWrBus;
                            cyc_q <= 1'b1;
                            stb_q <= 1'b1;
                            we_q  <= 1'b1;
                        end
                    end
                end
                StWrBus: begin
                    if (wbm_ack_i || wbm_err_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        adr_q <= adr_q + 32'd4;
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            st_q   <= StIdle;
                            busy_q <= 1'b0;
                        end else begin
                            st_q <= StWdata;
                        end
                    end
                end
                StRdBus: begin
                    if (wbm_ack_i || wbm_err_i) begin
                        rdata_q <= wbm_err_i ? 32'hFFFF_FFFF : wbm_dat_i;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        bidx_q  <= '0;
                        st_q    <= StTxData;
                    end
                end
                StTxData: begin
                    if (tx_load) begin
                        rdata_q <= {rdata_q[23:0], 8'h00};
                        bidx_q  <= bidx_q + 3'd1;
                    end else if (bidx_q == 3'd4 && tx_ready) begin
                        adr_q <= adr_q + 32'd4;
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            st_q   <= StIdle;
                            busy_q <= 1'b0;
                        end else begin
                            st_q  <= StRdBus;
                            cyc_q <= 1'b1;
                            stb_q <= 1'b1;
                        end
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign ser_tx    = ser_tx_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_debug_uart_wb_bridge.sv
// Scoreboard bench for debug_uart_wb_bridge: host UART driver, Wishbone slave model,
// and independent monitors for bus cycles and serial response bytes.
module tb_debug_uart_wb_bridge;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned TO_CYC  = 200;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        ser_rx   = 1'b1;
    logic        ser_tx;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        busy, frame_err;

    debug_uart_wb_bridge #(
        .CLK_DIV        (CLK_DIV),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } wb_op_t;

    int          checks = 0;
    int          errors = 0;
    wb_op_t      exp_wb[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    bit          err_mode = 1'b0;
    bit          stall    = 1'b0;
    int          cyc_starts = 0;
    int          fe_pulses  = 0;
    int          fe_cycles  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic uart_send(input logic [7:0] b, input bit good_stop);
        ser_rx = 1'b0;
        hold(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            hold(CLK_DIV);
        end
        ser_rx = good_stop;
        hold(CLK_DIV);
        ser_rx = 1'b1;
        if (!good_stop) hold(2 * CLK_DIV);
    endtask

    // Model: each command expands into word-level bus ops and response bytes.
    task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] wa,
                            input logic [31:0] first, input int mode);
        logic [7:0]  q[$];
        logic [31:0] a, d, v;
        wb_op_t      op;
        bit          valid;
        int          f0, c0;
        valid = (cmd == 8'h01) || (cmd == 8'h02);
        q.push_back(len);
        for (int k = 3; k >= 0; k--) q.push_back(wa[8*k +: 8]);
        a = {wa[29:0], 2'b00};
        if (valid) begin
            for (int i = 0; i < int'(len); i++) begin
                op.adr = a;
                op.we  = (cmd == 8'h01);
                op.dat = '0;
                if (cmd == 8'h01) begin
                    d = (i == 0) ? first : $urandom;
                    op.dat = d;
                    for (int k = 3; k >= 0; k--) q.push_back(d[8*k +: 8]);
                    if (!err_mode) model_mem[a] = d;
                end else begin
                    v = err_mode ? 32'hFFFF_FFFF : (model_mem.exists(a) ? model_mem[a] : init_val(a));
                    for (int k = 3; k >= 0; k--) exp_tx.push_back(v[8*k +: 8]);
                end
                exp_wb.push_back(op);
                a += 32'd4;
            end
        end
        uart_send(cmd, 1'b1);
        hold(4);
        check("busy_after_cmd", busy, valid);
        if (valid) begin
            for (int j = 0; j < q.size(); j++) begin
                uart_send(q[j], 1'b1);
                if (j == 0 && mode == 1) begin
                    hold(125);
                    check("busy_stall_a", busy, 1);
                    hold(125);
                    check("busy_stall_b", busy, 1);
                end
                if (j == 0 && mode == 2) begin
                    f0 = fe_pulses;
                    c0 = fe_cycles;
                    uart_send(8'hA5, 1'b0);
                    check("frame_err_pulses", fe_pulses - f0, 1);
                    check("frame_err_width", fe_cycles - c0, 1);
                    check("busy_after_bad_frame", busy, 1);
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy && n < 30000) begin
            hold(1);
            n++;
        end
        check({name, "_busy_low"}, busy, 0);
        hold(2 * CLK_DIV);
        check({name, "_wb_drained"}, exp_wb.size(), 0);
        check({name, "_tx_drained"}, exp_tx.size(), 0);
    endtask

    // Wishbone slave: random wait states, optional error responses, optional stall.
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge core_clk);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !stall) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    dly = $urandom_range(0, 3);
                    if (err_mode) begin
                        wbm_err_i = 1'b1;
                        wbm_ack_i = 1'($urandom_range(0, 1));
                        wbm_dat_i = $urandom;
                    end else begin
                        wbm_ack_i = 1'b1;
                        if (wbm_we_o) slave_mem[wbm_adr_o] = wbm_dat_o;
                        else wbm_dat_i = slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o]
                                                                     : init_val(wbm_adr_o);
                    end
                end
            end
        end
    end

    // Bus monitor: every new cycle must match the next expected op.
    initial begin
        logic   prev;
        wb_op_t e;
        prev = 1'b0;
        forever begin
            @(negedge core_clk);
            if (wbm_cyc_o && !prev) begin
                cyc_starts++;
                check("wb_sel_active", wbm_sel_o, 4'hF);
                check("wb_stb_active", wbm_stb_o, 1);
                if (exp_wb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got cycle adr 0x%08h we %0d, required none",
                             wbm_adr_o, wbm_we_o);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_adr", wbm_adr_o, e.adr);
                    check("wb_we", wbm_we_o, e.we);
                    if (e.we) check("wb_dat", wbm_dat_o, e.dat);
                end
            end
            if (!wbm_cyc_o && prev) begin
                check("wb_sel_idle", wbm_sel_o, 4'h0);
                check("wb_stb_idle", wbm_stb_o, 0);
                check("wb_we_idle", wbm_we_o, 0);
            end
            prev = wbm_cyc_o;
        end
    end

    // Serial monitor: decode 8N1 bytes on ser_tx and compare against the expected stream.
    initial begin
        logic [7:0] b;
        logic       sb, pb;
        forever begin
            @(negedge core_clk);
            if (ser_tx === 1'b0 && !core_rst) begin
                repeat (CLK_DIV / 2) @(negedge core_clk);
                sb = ser_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge core_clk);
                    b[i] = ser_tx;
                end
                repeat (CLK_DIV) @(negedge core_clk);
                pb = ser_tx;
                check("tx_start_bit", sb, 0);
                check("tx_stop_bit", pb, 1);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, required none", b);
                end else begin
                    check("tx_byte", b, exp_tx.pop_front());
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge core_clk);
            if (frame_err) fe_cycles++;
            if (frame_err && !prev) fe_pulses++;
            prev = frame_err;
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int s, n;
        model_mem[32'h0000_1000] = 32'h1234_5678;
        slave_mem[32'h0000_1000] = 32'h1234_5678;
        #12;
        check("rst_ser_tx", ser_tx, 1);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_we", wbm_we_o, 0);
        check("rst_sel", wbm_sel_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        hold(3);
        core_rst = 1'b0;
        hold(4);

        send_cmd(8'h02, 8'd1, 32'h0000_0400, 32'h0, 0);
        wait_done("read_1000");
        send_cmd(8'h01, 8'd1, 32'h0000_0400, 32'hDEAD_BEEF, 0);
        wait_done("write_1000");
        send_cmd(8'h02, 8'd1, 32'h0000_0400, 32'h0, 0);
        wait_done("readback_1000");
        send_cmd(8'h02, 8'd3, 32'h3FFF_FFFF, 32'h0, 0);
        wait_done("burst_wrap");

        err_mode = 1'b1;
        send_cmd(8'h02, 8'd1, 32'h0000_0404, 32'h0, 0);
        wait_done("read_err");
        err_mode = 1'b0;

        s = cyc_starts;
        send_cmd(8'h02, 8'd0, 32'h0000_1234, 32'h0, 0);
        wait_done("len0");
        check("len0_no_cycle", cyc_starts - s, 0);

        send_cmd(8'h55, 8'd0, 32'h0, 32'h0, 0);
        send_cmd(8'h01, 8'd2, 32'h0000_0402, 32'hCAFE_F00D, 0);
        wait_done("after_junk");

        send_cmd(8'h02, 8'd2, 32'h0000_0402, 32'h0, 2);
        wait_done("frame_err_cmd");

        ser_rx = 1'b0;
        hold(2);
        ser_rx = 1'b1;
        hold(3 * CLK_DIV);
        check("false_start_busy", busy, 0);
        send_cmd(8'h02, 8'd1, 32'h0000_0402, 32'h0, 0);
        wait_done("after_false_start");

        s = cyc_starts;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        uart_send(8'h01, 1'b1);
        uart_send(8'h02, 1'b1);
        hold(150);
        check("timeout_busy_before", busy, 1);
        hold(100);
        check("timeout_busy_after", busy, 0);
        check("timeout_no_cycle", cyc_starts - s, 0);
`else
        send_cmd(8'h01, 8'd2, 32'h0000_0406, 32'h1111_2222, 1);
        wait_done("no_timeout");
        check("no_timeout_cycles", cyc_starts - s, 2);
`endif

        for (int i = 0; i < 8; i++) begin
            err_mode = ($urandom_range(0, 3) == 0);
            send_cmd(8'($urandom_range(1, 2)), 8'($urandom_range(1, 3)),
                     32'h0000_0400 + 32'($urandom_range(0, 7)), $urandom, 0);
            wait_done("random_cmd");
        end
        err_mode = 1'b0;

        stall = 1'b1;
        send_cmd(8'h02, 8'd1, 32'h0000_0400, 32'h0, 0);
        n = 0;
        while (!wbm_cyc_o && n < 2000) begin
            hold(1);
            n++;
        end
        check("cyc_before_reset", wbm_cyc_o, 1);
        @(posedge core_clk);
        #3;
        core_rst = 1'b1;
        #1;
        check("async_rst_cyc", wbm_cyc_o, 0);
        check("async_rst_stb", wbm_stb_o, 0);
        check("async_rst_ser_tx", ser_tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_adr", wbm_adr_o, 0);
        hold(2);
        core_rst = 1'b0;
        stall = 1'b0;
        exp_tx.delete();
        hold(4);
        send_cmd(8'h02, 8'd1, 32'h0000_0401, 32'h0, 0);
        wait_done("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
